// File: rtl/instruction_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, execute (redirects) and decode.
// Handshake: a request or instruction transfers in a cycle where valid && ready are both
// high; the producer holds valid and payload until then, except that a redirect may withdraw
// an imem request. imem responses have no ready and are consumed whenever valid.
interface instruction_fetch_unit_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic                 imem_req_valid;
    logic                 imem_req_ready;
    logic [WORD_SIZE-1:0] imem_req_addr;
    logic                 imem_resp_valid;
    logic [WORD_SIZE-1:0] imem_resp_data;
    logic                 redirect_valid;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [WORD_SIZE-1:0] instruction;
    logic [WORD_SIZE-1:0] instr_pc;
    logic                 fetch_error;
    logic                 dbg_state;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
               fetch_error, dbg_state,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
               redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
               fetch_error, dbg_state,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid,
               redirect_pc, instr_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues word requests to instruction memory, buffers in-order responses and
// hands {instruction, pc} to decode; redirects flush the buffer and drop stale responses.
module instruction_fetch_unit #(
    parameter int unsigned          WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input logic                      clk,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);
    localparam int unsigned          AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned          CW        = AW + 1;
    localparam logic [CW:0]          DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [WORD_SIZE-1:0] PC_STEP   = WORD_SIZE'(4);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [WORD_SIZE-1:0] pc;
    } entry_t;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        drop_q, drop_d;
    logic [CW-1:0]        count_q, count_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    entry_t               buf_q [FIFO_DEPTH];
    entry_t               buf_d [FIFO_DEPTH];

    logic [CW:0]          in_flight;
    logic [CW-1:0]        outst_next;
    logic                 req_valid;
    logic                 req_fire;
    logic                 resp_take;
    logic                 resp_drop;
    logic                 resp_push;
    logic                 head_valid;
    logic                 head_pop;

    always_comb begin
        // Counting buffered entries together with outstanding requests reserves a slot
        // for every response before the request is issued, so responses never stall.
        in_flight  = {1'b0, outst_q} + {1'b0, count_q};
        req_valid  = !reset && (state_q == ST_RUN) && !bus.redirect_valid
                     && (in_flight < DEPTH_LIM);
        req_fire   = req_valid && bus.imem_req_ready;
        resp_take  = bus.imem_resp_valid && (outst_q != '0);
        resp_drop  = resp_take && (drop_q != '0);
        resp_push  = resp_take && (drop_q == '0);
        head_valid = !reset && (count_q != '0);
        head_pop   = head_valid && bus.instr_ready;
        outst_next = outst_q + CW'(req_fire) - CW'(resp_take);

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_next;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        buf_d      = buf_q;

        if (bus.redirect_valid) begin
            // Every request still in flight after this cycle belongs to the old stream.
            state_d    = (bus.redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            drop_d     = outst_next;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_push) begin
                buf_d[wr_ptr_q] = '{instr: bus.imem_resp_data, pc: resp_pc_q};
                wr_ptr_d        = wr_ptr_q + AW'(1);
                resp_pc_d       = resp_pc_q + PC_STEP;
            end
            if (head_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(resp_push) - CW'(head_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_q      <= buf_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instruction    = buf_q[rd_ptr_q].instr;
    assign bus.instr_pc       = buf_q[rd_ptr_q].pc;
    assign bus.fetch_error    = !reset && (state_q == ST_HALT);
    assign bus.dbg_state      = (state_q == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model with configurable latency and a
// stream-level reference (redirect epochs, expected pc queue) checked every cycle.
module tb_instruction_fetch_unit;
    localparam int W     = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [W-1:0] addr;
        int           due;
        int           epoch;
    } mem_entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.WORD_SIZE(W)) bus ();

    instruction_fetch_unit #(
        .WORD_SIZE (W),
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int           n_cmp = 0;
    int           n_mis = 0;
    int           cyc = 0;
    int           epoch = 0;
    int           buf_n = 0;
    int           last_due = 0;
    int           lat_min = 1;
    int           lat_max = 1;
    int           fires = 0;
    int           n_pops = 0;
    int           rel_cyc = -1;
    int           first_iv_cyc = -1;
    logic         halted = 1'b0;
    logic [W-1:0] next_req_pc = '0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] popped_q[$];
    logic [W-1:0] fire_q[$];
    mem_entry_t   mem_q[$];

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic drive_mem();
        if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom();
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        exp_q.delete();
        buf_n       = 0;
        next_req_pc = '0;
        halted      = 1'b0;
        last_due    = 0;
        epoch++;
    endtask

    // One clock cycle: inputs are already set; check outputs, advance the model, clock.
    task automatic step();
        logic         redir;
        logic         fire;
        logic         pop;
        logic         exp_rv;
        logic         exp_iv;
        logic [W-1:0] tgt;
        logic [W-1:0] head;
        mem_entry_t   e;
        int           due;
        #1;
        if (reset) begin
            n_cmp++;
            if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.fetch_error !== 1'b0) begin
                n_mis++;
                $display("FAIL reset_outputs: got req_valid=%b instr_valid=%b fetch_error=%b, expected 0 0 0",
                         bus.imem_req_valid, bus.instr_valid, bus.fetch_error);
            end
            model_reset();
            rel_cyc      = -1;
            first_iv_cyc = -1;
        end else begin
            if (rel_cyc < 0) rel_cyc = cyc;
            if (first_iv_cyc < 0 && bus.instr_valid === 1'b1) first_iv_cyc = cyc;
            redir  = bus.redirect_valid;
            tgt    = bus.redirect_pc;
            exp_rv = !halted && !redir && (mem_q.size() + buf_n < DEPTH);
            exp_iv = (buf_n != 0);
            n_cmp++;
            if (bus.imem_req_valid !== exp_rv) begin
                n_mis++;
                $display("FAIL req_valid @%0d: got %b expected %b", cyc, bus.imem_req_valid, exp_rv);
            end
            n_cmp++;
            if (bus.instr_valid !== exp_iv) begin
                n_mis++;
                $display("FAIL instr_valid @%0d: got %b expected %b", cyc, bus.instr_valid, exp_iv);
            end
            n_cmp++;
            if (bus.fetch_error !== halted) begin
                n_mis++;
                $display("FAIL fetch_error @%0d: got %b expected %b", cyc, bus.fetch_error, halted);
            end
            if (exp_rv && bus.imem_req_valid === 1'b1) begin
                n_cmp++;
                if (bus.imem_req_addr !== next_req_pc) begin
                    n_mis++;
                    $display("FAIL req_addr @%0d: got %h expected %h", cyc, bus.imem_req_addr, next_req_pc);
                end
            end
            if (exp_iv && bus.instr_valid === 1'b1) begin
                head = exp_q[0];
                n_cmp++;
                if (bus.instr_pc !== head) begin
                    n_mis++;
                    $display("FAIL instr_pc @%0d: got %h expected %h", cyc, bus.instr_pc, head);
                end
                n_cmp++;
                if (bus.instruction !== mem_word(head)) begin
                    n_mis++;
                    $display("FAIL instruction @%0d: got %h expected %h", cyc, bus.instruction, mem_word(head));
                end
            end
            fire = (bus.imem_req_valid === 1'b1) && bus.imem_req_ready;
            pop  = exp_iv && (bus.instr_valid === 1'b1) && bus.instr_ready && !redir;
            if (bus.imem_resp_valid && mem_q.size() > 0) begin
                e = mem_q.pop_front();
                if (e.epoch == epoch && !redir) buf_n++;
            end
            if (fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.addr  = next_req_pc;
                e.due   = due;
                e.epoch = epoch;
                mem_q.push_back(e);
                exp_q.push_back(next_req_pc);
                fire_q.push_back(bus.imem_req_addr);
                next_req_pc = next_req_pc + 32'd4;
                fires++;
            end
            if (pop) begin
                popped_q.push_back(exp_q.pop_front());
                buf_n--;
                n_pops++;
            end
            if (redir) begin
                epoch++;
                exp_q.delete();
                buf_n       = 0;
                next_req_pc = tgt;
                halted      = (tgt[1:0] != 2'b00);
            end
        end
        @(negedge clk);
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset(input int lat);
        lat_min            = lat;
        lat_max            = lat;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        reset              = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        popped_q.delete();
        fire_q.delete();
        fires = 0;
    endtask

    task automatic test_reset();
        logic [W-1:0] want;
        do_reset(1);
        repeat (10) step();
        n_cmp++;
        if (first_iv_cyc - rel_cyc != 2) begin
            n_mis++;
            $display("FAIL first_valid_latency: got %0d expected 2", first_iv_cyc - rel_cyc);
        end
        n_cmp++;
        if (popped_q.size() < 3 || fire_q.size() < 3) begin
            n_mis++;
            $display("FAIL stream_length: got pops=%0d fires=%0d expected >=3", popped_q.size(), fire_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = 32'(i * 4);
                n_cmp++;
                if (fire_q[i] !== want || popped_q[i] !== want) begin
                    n_mis++;
                    $display("FAIL reset_stream[%0d]: got addr=%h pc=%h expected %h", i, fire_q[i], popped_q[i], want);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] want;
        do_reset(1);
        bus.instr_ready = 1'b0;
        repeat (10) step();
        n_cmp++;
        if (fires != 2 || bus.imem_req_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL stall_requests: got fires=%0d req_valid=%b expected 2 0", fires, bus.imem_req_valid);
        end
        bus.instr_ready = 1'b1;
        repeat (10) step();
        n_cmp++;
        if (popped_q.size() < 3) begin
            n_mis++;
            $display("FAIL release_pops: got %0d expected >=3", popped_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                want = 32'(i * 4);
                n_cmp++;
                if (popped_q[i] !== want) begin
                    n_mis++;
                    $display("FAIL release_pc[%0d]: got %h expected %h", i, popped_q[i], want);
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(3);
        repeat (2) step();
        n_cmp++;
        if (fires != 2) begin
            n_mis++;
            $display("FAIL outstanding_before_redirect: got %0d expected 2", fires);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        popped_q.delete();
        repeat (15) step();
        n_cmp++;
        if (popped_q.size() < 2 || popped_q[0] !== 32'h100 || popped_q[1] !== 32'h104) begin
            n_mis++;
            $display("FAIL redirect_stream: got n=%0d first=%h expected 100 104",
                     popped_q.size(), (popped_q.size() > 0) ? popped_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_collision();
        int k;
        do_reset(1);
        k = 0;
        while (!(bus.imem_resp_valid && bus.instr_valid === 1'b1) && k < 20) begin
            step();
            k++;
        end
        n_cmp++;
        if (k >= 20) begin
            n_mis++;
            $display("FAIL collision_setup: got no push/pop cycle within %0d cycles, expected one", k);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step();
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if (bus.instr_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL flush_after_collision: got instr_valid=%b expected 0", bus.instr_valid);
        end
        popped_q.delete();
        repeat (10) step();
        n_cmp++;
        if (popped_q.size() < 1 || popped_q[0] !== 32'h400) begin
            n_mis++;
            $display("FAIL collision_new_stream: got n=%0d expected first pc 400", popped_q.size());
        end
    endtask

    task automatic test_misaligned();
        do_reset(2);
        repeat (5) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
        fires = 0;
        repeat (20) step();
        n_cmp++;
        if (fires != 0 || bus.fetch_error !== 1'b1) begin
            n_mis++;
            $display("FAIL halt_hold: got fires=%0d fetch_error=%b expected 0 1", fires, bus.fetch_error);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        step();
        bus.redirect_valid = 1'b0;
        fire_q.delete();
        n_cmp++;
        if (bus.fetch_error !== 1'b0) begin
            n_mis++;
            $display("FAIL halt_exit: got fetch_error=%b expected 0", bus.fetch_error);
        end
        step();
        n_cmp++;
        if (fire_q.size() != 1 || fire_q[0] !== 32'h200) begin
            n_mis++;
            $display("FAIL resume_addr: got n=%0d expected one request at 200", fire_q.size());
        end
    endtask

    task automatic test_stall_wrap();
        do_reset(1);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
                n_mis++;
                $display("FAIL stall_hold[%0d]: got valid=%b addr=%h expected 1 0", i, bus.imem_req_valid, bus.imem_req_addr);
            end
        end
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        fire_q.delete();
        repeat (4) step();
        n_cmp++;
        if (fire_q.size() < 2 || fire_q[0] !== 32'hFFFF_FFFC || fire_q[1] !== 32'h0) begin
            n_mis++;
            $display("FAIL wrap_addrs: got n=%0d first=%h expected fffffffc 00000000",
                     fire_q.size(), (fire_q.size() > 0) ? fire_q[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] pc;
        int           pops_start;
        do_reset(1);
        lat_min    = 1;
        lat_max    = 4;
        pops_start = n_pops;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.instr_ready    = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = 1'b0;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 7))
                    0:       pc = {$urandom()} | 32'(($urandom_range(1, 3)));
                    1:       pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                    default: pc = {$urandom()} & 32'hFFFF_FFFC;
                endcase
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = pc;
            end
            reset = ($urandom_range(0, 499) == 0);
            if (reset) bus.redirect_valid = 1'b0;
            step();
            reset = 1'b0;
        end
        n_cmp++;
        if (n_pops - pops_start < 100) begin
            n_mis++;
            $display("FAIL random_throughput: got %0d pops expected >=100", n_pops - pops_start);
        end
    endtask

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b1;
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collision();
        test_misaligned();
        test_stall_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
